// File: rtl/router_fifo.sv
// Per-destination packet FIFO behind the router Register stage. Each stored
// word carries a header tag so the read side can find packet boundaries.
module router_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             soft_reset,
    input  logic             write_enb,
    input  logic             read_enb,
    input  logic             lfd_state,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             full,
    output logic             empty,
    output logic             pkt_end
);

    localparam logic [AW:0]   OCC_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   OCC_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [WIDTH:0]   mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      occ_q, occ_d;
    logic [5:0]       pkt_cnt_q, pkt_cnt_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic             pkt_end_q, pkt_end_d;

    logic             wr_acc;
    logic             rd_acc;
    logic [WIDTH:0]   rd_word;

    assign full    = (occ_q == OCC_FULL);
    assign empty   = (occ_q == '0);
    assign wr_acc  = write_enb && !full;
    assign rd_acc  = read_enb && !empty;
    assign rd_word = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        occ_d      = occ_q;
        pkt_cnt_d  = pkt_cnt_q;
        data_out_d = data_out_q;
        pkt_end_d  = 1'b0;

        if (soft_reset) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            occ_d      = '0;
            pkt_cnt_d  = '0;
            data_out_d = '0;
        end else begin
            if (wr_acc) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end

            if (rd_acc) begin
                rd_ptr_d   = rd_ptr_q + PTR_ONE;
                data_out_d = rd_word[WIDTH-1:0];
                // Header length field counts payload bytes; +1 covers parity.
                if (rd_word[WIDTH]) begin
                    pkt_cnt_d = rd_word[WIDTH-1:WIDTH-6] + 6'd1;
                end else if (pkt_cnt_q != 6'd0) begin
                    pkt_cnt_d = pkt_cnt_q - 6'd1;
                    pkt_end_d = (pkt_cnt_q == 6'd1);
                end
            end else if (pkt_end_q) begin
                data_out_d = '0;
            end

            unique case ({wr_acc, rd_acc})
                2'b10:   occ_d = occ_q + OCC_ONE;
                2'b01:   occ_d = occ_q - OCC_ONE;
                default: occ_d = occ_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
            pkt_cnt_q  <= '0;
            data_out_q <= '0;
            pkt_end_q  <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            occ_q      <= occ_d;
            pkt_cnt_q  <= pkt_cnt_d;
            data_out_q <= data_out_d;
            pkt_end_q  <= pkt_end_d;
        end
    end

    // Storage is not reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (wr_acc && !soft_reset) begin
            mem_q[wr_ptr_q] <= {lfd_state, data_in};
        end
    end

    assign data_out = data_out_q;
    assign pkt_end  = pkt_end_q;

endmodule

// File: tb/tb_router_fifo.sv
// Scoreboard bench for router_fifo: a queue model predicts every read byte and
// pkt_end pulse, and each scenario task compares DUT outputs against it.
`timescale 1ns/1ps
module tb_router_fifo;
    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       soft_reset;
    logic       write_enb;
    logic       read_enb;
    logic       lfd_state;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       full;
    logic       empty;
    logic       pkt_end;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [7:0] d;
        logic       pe;
    } exp_t;

    exp_t       sb[$];
    logic [8:0] mdl[$];
    logic [5:0] mcnt;
    logic [7:0] m_dout;
    logic       m_pend;

    router_fifo #(.WIDTH(8), .DEPTH(16), .AW(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .soft_reset (soft_reset),
        .write_enb  (write_enb),
        .read_enb   (read_enb),
        .lfd_state  (lfd_state),
        .data_in    (data_in),
        .data_out   (data_out),
        .full       (full),
        .empty      (empty),
        .pkt_end    (pkt_end)
    );

    always #5 clk = ~clk;

    task automatic model_clear();
        mdl.delete();
        sb.delete();
        mcnt   = 6'd0;
        m_dout = 8'h00;
        m_pend = 1'b0;
    endtask

    // One clock of stimulus; the model predicts the result of the edge.
    task automatic drive(input logic we, input logic re, input logic tag,
                         input logic [7:0] d, input logic sr, output logic racc);
        logic [8:0] w;
        logic       pend;
        logic       wacc;
        exp_t       e;
        write_enb  = we;
        read_enb   = re;
        lfd_state  = tag;
        data_in    = d;
        soft_reset = sr;
        racc = re && (mdl.size() != 0) && !sr;
        wacc = we && (mdl.size() != DEPTH) && !sr;
        if (sr) begin
            model_clear();
        end else if (racc) begin
            w    = mdl.pop_front();
            pend = 1'b0;
            if (w[8]) begin
                mcnt = w[7:2] + 6'd1;
            end else if (mcnt != 6'd0) begin
                pend = (mcnt == 6'd1);
                mcnt = mcnt - 6'd1;
            end
            m_dout = w[7:0];
            m_pend = pend;
            e.d    = w[7:0];
            e.pe   = pend;
            sb.push_back(e);
        end else begin
            if (m_pend) m_dout = 8'h00;
            m_pend = 1'b0;
        end
        if (wacc) mdl.push_back({tag, d});
        @(posedge clk);
        #1;
        write_enb  = 1'b0;
        read_enb   = 1'b0;
        lfd_state  = 1'b0;
        soft_reset = 1'b0;
    endtask

    task automatic write_pkt(input logic [7:0] hdr);
        logic       r;
        logic [7:0] par;
        logic [7:0] b;
        par = hdr;
        drive(1'b1, 1'b0, 1'b1, hdr, 1'b0, r);
        for (int k = 0; k < int'(hdr[7:2]); k++) begin
            b   = 8'h11 * 8'(k + 1);
            par = par ^ b;
            drive(1'b1, 1'b0, 1'b0, b, 1'b0, r);
        end
        drive(1'b1, 1'b0, 1'b0, par, 1'b0, r);
    endtask

    task automatic test_reset();
        model_clear();
        rst = 1'b1; soft_reset = 1'b0; read_enb = 1'b0;
        write_enb = 1'b1; lfd_state = 1'b1; data_in = 8'hAA;
        #3 rst = 1'b0;
        @(posedge clk);
        #2;
        checks++;
        if (empty !== 1'b1 || full !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags: empty=%b full=%b expected 1/0", empty, full);
        end
        checks++;
        if (data_out !== 8'h00 || pkt_end !== 1'b0) begin
            failures++;
            $display("FAIL reset_outs: data_out=%h pkt_end=%b expected 00/0", data_out, pkt_end);
        end
        #1 rst = 1'b1;
        write_enb = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (empty !== 1'b1) begin
            failures++;
            $display("FAIL reset_nowrite: empty=%b expected 1", empty);
        end
    endtask

    task automatic test_single_packet();
        logic r;
        exp_t e;
        int   pulses = 0;
        write_pkt(8'h16);
        for (int i = 0; i < 7; i++) begin
            drive(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, r);
            if (pkt_end === 1'b1) pulses++;
            if (r) begin
                e = sb.pop_front();
                checks++;
                if (data_out !== e.d || pkt_end !== e.pe) begin
                    failures++;
                    $display("FAIL single_rd%0d: data_out=%h pkt_end=%b expected %h/%b",
                             i, data_out, pkt_end, e.d, e.pe);
                end
            end
        end
        checks++;
        if (pulses != 1 || empty !== 1'b1) begin
            failures++;
            $display("FAIL single_end: pulses=%0d empty=%b expected 1/1", pulses, empty);
        end
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, r);
        checks++;
        if (data_out !== 8'h00 || pkt_end !== 1'b0) begin
            failures++;
            $display("FAIL single_idle_clear: data_out=%h pkt_end=%b expected 00/0", data_out, pkt_end);
        end
    endtask

    task automatic test_zero_len();
        logic r;
        exp_t e;
        drive(1'b1, 1'b0, 1'b1, 8'h01, 1'b0, r);
        drive(1'b1, 1'b0, 1'b0, 8'h01, 1'b0, r);
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, r);
            if (r) begin
                e = sb.pop_front();
                checks++;
                if (data_out !== e.d || pkt_end !== e.pe) begin
                    failures++;
                    $display("FAIL zero_len_rd%0d: data_out=%h pkt_end=%b expected %h/%b",
                             i, data_out, pkt_end, e.d, e.pe);
                end
            end
        end
        checks++;
        if (pkt_end !== 1'b1) begin
            failures++;
            $display("FAIL zero_len_pulse: pkt_end=%b expected 1", pkt_end);
        end
    endtask

    task automatic test_full();
        logic r;
        exp_t e;
        int   n = 0;
        for (int i = 0; i < DEPTH; i++) drive(1'b1, 1'b0, 1'b0, 8'h40 + 8'(i), 1'b0, r);
        checks++;
        if (full !== 1'b1 || empty !== 1'b0) begin
            failures++;
            $display("FAIL full_set: full=%b empty=%b expected 1/0", full, empty);
        end
        drive(1'b1, 1'b0, 1'b0, 8'hEE, 1'b0, r);
        checks++;
        if (full !== 1'b1) begin
            failures++;
            $display("FAIL full_drop: full=%b expected 1", full);
        end
        drive(1'b1, 1'b1, 1'b0, 8'hDD, 1'b0, r);
        e = sb.pop_front();
        checks++;
        if (full !== 1'b0 || data_out !== e.d) begin
            failures++;
            $display("FAIL full_rw: full=%b data_out=%h expected 0/%h", full, data_out, e.d);
        end
        for (int i = 0; i < DEPTH + 2; i++) begin
            drive(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, r);
            if (r) begin
                n++;
                e = sb.pop_front();
                checks++;
                if (data_out !== e.d || pkt_end !== e.pe) begin
                    failures++;
                    $display("FAIL full_drain%0d: data_out=%h pkt_end=%b expected %h/%b",
                             i, data_out, pkt_end, e.d, e.pe);
                end
            end
        end
        checks++;
        if (n != 15 || empty !== 1'b1) begin
            failures++;
            $display("FAIL full_count: drained=%0d empty=%b expected 15/1", n, empty);
        end
    endtask

    task automatic test_wrap();
        logic r;
        exp_t e;
        int   counts[2] = '{12, 10};
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < counts[p]; i++) begin
                drive(1'b1, 1'b0, 1'b0, 8'h80 + 8'(p * 16 + i), 1'b0, r);
                checks++;
                if (full !== 1'b0) begin
                    failures++;
                    $display("FAIL wrap_full%0d_%0d: full=%b expected 0", p, i, full);
                end
            end
            for (int i = 0; i < counts[p]; i++) begin
                drive(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, r);
                if (r) begin
                    e = sb.pop_front();
                    checks++;
                    if (data_out !== e.d || pkt_end !== e.pe) begin
                        failures++;
                        $display("FAIL wrap_rd%0d_%0d: data_out=%h pkt_end=%b expected %h/%b",
                                 p, i, data_out, pkt_end, e.d, e.pe);
                    end
                end
            end
            checks++;
            if (empty !== 1'b1) begin
                failures++;
                $display("FAIL wrap_empty%0d: empty=%b expected 1", p, empty);
            end
        end
    endtask

    task automatic test_soft_reset();
        logic r;
        exp_t e;
        write_pkt(8'h16);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, r);
            e = sb.pop_front();
        end
        drive(1'b1, 1'b1, 1'b1, 8'h77, 1'b1, r);
        checks++;
        if (empty !== 1'b1 || full !== 1'b0 || data_out !== 8'h00 || pkt_end !== 1'b0) begin
            failures++;
            $display("FAIL soft_clear: empty=%b full=%b data_out=%h pkt_end=%b expected 1/0/00/0",
                     empty, full, data_out, pkt_end);
        end
        // Stray bytes would end a packet here if the packet counter survived.
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 1'b0, 8'hC0 + 8'(i), 1'b0, r);
        write_pkt(8'h08);
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, r);
            if (r) begin
                e = sb.pop_front();
                checks++;
                if (data_out !== e.d || pkt_end !== e.pe) begin
                    failures++;
                    $display("FAIL soft_rd%0d: data_out=%h pkt_end=%b expected %h/%b",
                             i, data_out, pkt_end, e.d, e.pe);
                end
            end
        end
        checks++;
        if (pkt_end !== 1'b1 || empty !== 1'b1) begin
            failures++;
            $display("FAIL soft_pkt_end: pkt_end=%b empty=%b expected 1/1", pkt_end, empty);
        end
    endtask

    task automatic test_async_reset();
        logic r;
        exp_t e;
        write_pkt(8'h0C);
        drive(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, r);
        drive(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, r);
        #2 rst = 1'b0;
        #1;
        checks++;
        if (data_out !== 8'h00 || pkt_end !== 1'b0 || empty !== 1'b1 || full !== 1'b0) begin
            failures++;
            $display("FAIL async_clear: data_out=%h pkt_end=%b empty=%b full=%b expected 00/0/1/0",
                     data_out, pkt_end, empty, full);
        end
        #2 rst = 1'b1;
        model_clear();
        drive(1'b1, 1'b0, 1'b1, 8'h04, 1'b0, r);
        checks++;
        if (empty !== 1'b0) begin
            failures++;
            $display("FAIL async_first_wr: empty=%b expected 0", empty);
        end
        drive(1'b1, 1'b0, 1'b0, 8'h5A, 1'b0, r);
        drive(1'b1, 1'b0, 1'b0, 8'h04 ^ 8'h5A, 1'b0, r);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, r);
            if (r) begin
                e = sb.pop_front();
                checks++;
                if (data_out !== e.d || pkt_end !== e.pe) begin
                    failures++;
                    $display("FAIL async_rd%0d: data_out=%h pkt_end=%b expected %h/%b",
                             i, data_out, pkt_end, e.d, e.pe);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_packet();
        test_zero_len();
        test_full();
        test_wrap();
        test_soft_reset();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
